// File: rtl/axi_lite_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram_responder
// Brief    : AXI4-Lite slave that maps AW/W/AR traffic onto a single-port
//            synchronous SRAM (1-cycle read latency, byte write mask).
// Revision : 1.0  initial release
// ============================================================================
module axi_lite_sram_responder #(
  parameter int MEM_AW = 9,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_wmask,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_BRESP = 3'd2,
    S_RD    = 3'd3,
    S_RCAP  = 3'd4,
    S_RRESP = 3'd5
  } state_t;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_aw_full;
  logic              r_aw_oor;
  logic [MEM_AW-1:0] r_aw_waddr;
  logic              r_w_full;
  logic [31:0]       r_w_data;
  logic [3:0]        r_w_strb;
  logic              r_prio_wr;
  logic              r_wr_err;
  logic              r_rd_err;

  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_arready;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              r_sram_cs;
  logic              r_sram_we;
  logic [MEM_AW-1:0] r_sram_addr;
  logic [31:0]       r_sram_wdata;
  logic [3:0]        r_sram_wmask;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_rd_take;
  logic w_wr_take;
  logic w_aw_full_nxt;
  logic w_w_full_nxt;
  logic w_prio_nxt;
  logic w_aw_oor_in;
  logic w_ar_oor_in;
  logic w_unused_addr_lsbs;

  // Byte offset bits never select anything in a word-wide window.
  assign w_unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign w_aw_oor_in = |s_awaddr[ADDR_W-1:MEM_AW+2];
  assign w_ar_oor_in = |s_araddr[ADDR_W-1:MEM_AW+2];

  assign w_aw_hs   = r_awready & s_awvalid;
  assign w_w_hs    = r_wready & s_wvalid;
  // arready is only raised when a pending write does not own the slot,
  // so an AR handshake in IDLE always wins the arbitration.
  assign w_rd_take = (r_state == S_IDLE) & r_arready & s_arvalid;
  assign w_wr_take = (r_state == S_IDLE) & ~w_rd_take & r_aw_full & r_w_full;

  assign w_aw_full_nxt = w_wr_take ? 1'b0 : (r_aw_full | w_aw_hs);
  assign w_w_full_nxt  = w_wr_take ? 1'b0 : (r_w_full | w_w_hs);
  assign w_prio_nxt    = w_rd_take ? 1'b1 : (w_wr_take ? 1'b0 : r_prio_wr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_take) begin
          w_state_nxt = S_RD;
        end else if (w_wr_take) begin
          w_state_nxt = S_WR;
        end
      end
      S_WR:    w_state_nxt = S_BRESP;
      S_BRESP: if (s_bready) w_state_nxt = S_IDLE;
      S_RD:    w_state_nxt = S_RCAP;
      S_RCAP:  w_state_nxt = S_RRESP;
      S_RRESP: if (s_rready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aw_full    <= 1'b0;
      r_aw_oor     <= 1'b0;
      r_aw_waddr   <= '0;
      r_w_full     <= 1'b0;
      r_w_data     <= '0;
      r_w_strb     <= '0;
      r_prio_wr    <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_err     <= 1'b0;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= '0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rresp      <= '0;
      r_sram_cs    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_wmask <= '0;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_prio_wr <= w_prio_nxt;
      r_awready <= ~w_aw_full_nxt;
      r_wready  <= ~w_w_full_nxt;
      r_arready <= (w_state_nxt == S_IDLE) & ~(w_aw_full_nxt & w_w_full_nxt & w_prio_nxt);

      if (w_aw_hs) begin
        r_aw_waddr <= s_awaddr[MEM_AW+1:2];
        r_aw_oor   <= w_aw_oor_in;
      end
      if (w_w_hs) begin
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end

      // Address/data/mask only move with a real SRAM access.
      r_sram_cs <= 1'b0;
      r_sram_we <= 1'b0;
      if (w_rd_take) begin
        r_rd_err <= w_ar_oor_in;
        if (!w_ar_oor_in) begin
          r_sram_cs   <= 1'b1;
          r_sram_addr <= s_araddr[MEM_AW+1:2];
        end
      end else if (w_wr_take) begin
        r_wr_err <= r_aw_oor;
        if (!r_aw_oor) begin
          r_sram_cs    <= 1'b1;
          r_sram_we    <= 1'b1;
          r_sram_addr  <= r_aw_waddr;
          r_sram_wdata <= r_w_data;
          r_sram_wmask <= r_w_strb;
        end
      end

      r_bvalid <= (w_state_nxt == S_BRESP);
      if (r_state == S_WR) begin
        r_bresp <= r_wr_err ? c_resp_slverr : c_resp_okay;
      end else if (w_state_nxt != S_BRESP) begin
        r_bresp <= c_resp_okay;
      end

      r_rvalid <= (w_state_nxt == S_RRESP);
      if (r_state == S_RCAP) begin
        r_rdata <= r_rd_err ? 32'h0 : sram_rdata;
        r_rresp <= r_rd_err ? c_resp_slverr : c_resp_okay;
      end else if (w_state_nxt != S_RRESP) begin
        r_rresp <= c_resp_okay;
      end
    end
  end

  assign s_awready  = r_awready;
  assign s_wready   = r_wready;
  assign s_bvalid   = r_bvalid;
  assign s_bresp    = r_bresp;
  assign s_arready  = r_arready;
  assign s_rvalid   = r_rvalid;
  assign s_rdata    = r_rdata;
  assign s_rresp    = r_rresp;
  assign sram_cs    = r_sram_cs;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_wmask = r_sram_wmask;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_sram_responder
// Brief    : Directed, table-driven bench for axi_lite_sram_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_sram_responder;

  localparam int MEM_AW = 9;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              s_awvalid = 1'b0;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [31:0]       s_wdata = '0;
  logic [3:0]        s_wstrb = '0;
  logic              s_bvalid;
  logic              s_bready = 1'b0;
  logic [1:0]        s_bresp;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr = '0;
  logic              s_rvalid;
  logic              s_rready = 1'b0;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              sram_cs;
  logic              sram_we;
  logic [MEM_AW-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [3:0]        sram_wmask;
  logic [31:0]       sram_rdata;

  always #5 clk = ~clk;

  axi_lite_sram_responder #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  // Behavioural single-port SRAM with one cycle of read latency.
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  initial begin
    for (int i = 0; i < (1<<MEM_AW); i++) mem[i] <= 32'h0;
  end
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // SRAM access monitor.
  int              cs_cnt = 0;
  int              we_cnt = 0;
  logic [8:0]      last_waddr = '0;
  logic [3:0]      last_wmask = '0;
  bit              we_log[$];
  always @(negedge clk) begin
    if (sram_cs) begin
      cs_cnt++;
      we_log.push_back(sram_we);
      if (sram_we) begin
        we_cnt++;
        last_waddr = sram_addr;
        last_wmask = sram_wmask;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_output();
    return |{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata,
             s_rresp, sram_cs, sram_we, sram_addr, sram_wdata, sram_wmask};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Entered and left on a falling edge; lat counts edges from the later of
  // the AW/W handshakes to the first visible bvalid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp, output int lat);
    bit aw_hs, w_hs, aw_done, w_done;
    int k_full;
    resp = 2'b11; lat = -1; aw_done = 0; w_done = 0; k_full = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    for (int k = 0; k < 40; k++) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      if (s_bvalid) begin
        resp = s_bresp; lat = k - k_full;
        break;
      end
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if ((aw_hs || w_hs) && aw_done && w_done) k_full = k;
      @(negedge clk);
      if (aw_hs) s_awvalid = 0;
      if (w_hs) s_wvalid = 0;
    end
    @(negedge clk);
    s_bready = 0; s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                         output logic [31:0] data, output int lat);
    bit ar_hs;
    int k_ar;
    resp = 2'b11; data = 32'hFFFF_FFFF; lat = -1; k_ar = 0;
    s_araddr = a; s_arvalid = 1; s_rready = 1;
    for (int k = 0; k < 40; k++) begin
      ar_hs = s_arvalid && s_arready;
      if (s_rvalid) begin
        resp = s_rresp; data = s_rdata; lat = k - k_ar;
        break;
      end
      if (ar_hs) k_ar = k;
      @(negedge clk);
      if (ar_hs) s_arvalid = 0;
    end
    @(negedge clk);
    s_rready = 0; s_arvalid = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [8:0]  waddr;
  } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    int          cs0, we0;

    tv[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00, 32'h0,         9'd4};
    tv[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 2'b00, 32'hDEAD_BEEF, 9'd0};
    tv[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 2'b00, 32'h0,         9'd8};
    tv[3]  = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 2'b00, 32'h0,         9'd8};
    tv[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 2'b00, 32'h1122_AB44, 9'd0};
    tv[5]  = '{1'b1, 32'h0000_0024, 32'h5566_7788, 4'b1111, 2'b00, 32'h0,         9'd9};
    tv[6]  = '{1'b1, 32'h0000_0024, 32'hAABB_CCDD, 4'b0000, 2'b00, 32'h0,         9'd9};
    tv[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'b0000, 2'b00, 32'h5566_7788, 9'd0};
    tv[8]  = '{1'b0, 32'h0000_0800, 32'h0,         4'b0000, 2'b10, 32'h0,         9'd0};
    tv[9]  = '{1'b1, 32'h0000_0800, 32'h1234_5678, 4'b1111, 2'b10, 32'h0,         9'd0};
    tv[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 2'b00, 32'h0,         9'd0};
    tv[11] = '{1'b1, 32'h0000_07FF, 32'hCAFE_F00D, 4'b1111, 2'b00, 32'h0,         9'd511};
    tv[12] = '{1'b0, 32'h0000_07FC, 32'h0,         4'b0000, 2'b00, 32'hCAFE_F00D, 9'd0};
    tv[13] = '{1'b1, 32'h8000_0010, 32'h9999_9999, 4'b1111, 2'b10, 32'h0,         9'd0};
    tv[14] = '{1'b1, 32'h0000_0013, 32'h0102_0304, 4'b1001, 2'b00, 32'h0,         9'd4};
    tv[15] = '{1'b0, 32'h0000_0011, 32'h0,         4'b0000, 2'b00, 32'h01AD_BE04, 9'd0};

    // Reset state, then readies after release.
    @(negedge clk);
    chk("reset outputs", any_output(), 1'b0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("awready after reset", s_awready, 1'b1);
    chk("wready after reset", s_wready, 1'b1);
    chk("arready after reset", s_arready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      cs0 = cs_cnt; we0 = we_cnt;
      if (tv[i].wr) begin
        do_write(tv[i].addr, tv[i].data, tv[i].strb, resp, lat);
        chk($sformatf("v%0d bresp", i), resp, tv[i].resp);
        chk($sformatf("v%0d write latency", i), lat, 3);
        chk($sformatf("v%0d sram writes", i), we_cnt - we0, (tv[i].resp == 2'b00) ? 1 : 0);
        if (tv[i].resp == 2'b00) begin
          chk($sformatf("v%0d sram waddr", i), last_waddr, tv[i].waddr);
          chk($sformatf("v%0d sram wmask", i), last_wmask, tv[i].strb);
        end
      end else begin
        do_read(tv[i].addr, resp, data, lat);
        chk($sformatf("v%0d rresp", i), resp, tv[i].resp);
        chk($sformatf("v%0d rdata", i), data, tv[i].rdata);
        chk($sformatf("v%0d read latency", i), lat, 3);
        chk($sformatf("v%0d sram selects", i), cs_cnt - cs0, (tv[i].resp == 2'b00) ? 1 : 0);
      end
    end

    // W ahead of AW by several cycles.
    s_wdata = 32'hA5A5_0F0F; s_wstrb = 4'b1111; s_wvalid = 1; s_bready = 1;
    chk("t2 wready before W", s_wready, 1'b1);
    @(negedge clk);
    s_wvalid = 0;
    chk("t2 wready held off", s_wready, 1'b0);
    chk("t2 awready still open", s_awready, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2 no early access", sram_cs, 1'b0);
    s_awaddr = 32'h0000_0030; s_awvalid = 1;
    @(negedge clk);
    s_awvalid = 0;
    chk("t2 bvalid not yet", s_bvalid, 1'b0);
    @(negedge clk);
    chk("t2 sram cs/we", {sram_cs, sram_we}, 2'b11);
    chk("t2 sram addr", sram_addr, 9'd12);
    chk("t2 wready reopened", s_wready, 1'b1);
    @(negedge clk);
    chk("t2 bvalid", s_bvalid, 1'b1);
    chk("t2 bresp", s_bresp, 2'b00);
    @(negedge clk);
    s_bready = 0;
    chk("t2 bvalid dropped", s_bvalid, 1'b0);
    do_read(32'h0000_0030, resp, data, lat);
    chk("t2 readback", data, 32'hA5A5_0F0F);

    // Simultaneous write and reads from a fresh reset.
    do_reset();
    we_log.delete();
    begin
      bit aw_hs, w_hs, ar_hs;
      int nr, nb, nar;
      logic [31:0] rd [2];
      logic [2:0]  seq;
      nr = 0; nb = 0; nar = 0; rd[0] = 32'hFFFF_FFFF; rd[1] = 32'hFFFF_FFFF;
      s_awaddr = 32'h0000_0040; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'b1111;
      s_araddr = 32'h0000_0040;
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_rready = 1; s_bready = 1;
      for (int k = 0; k < 40 && !(nr == 2 && nb == 1); k++) begin
        aw_hs = s_awvalid && s_awready;
        w_hs  = s_wvalid && s_wready;
        ar_hs = s_arvalid && s_arready;
        if (s_rvalid && nr < 2) begin rd[nr] = s_rdata; nr++; end
        if (s_bvalid) nb++;
        @(negedge clk);
        if (aw_hs) s_awvalid = 0;
        if (w_hs) s_wvalid = 0;
        if (ar_hs) begin nar++; if (nar == 2) s_arvalid = 0; end
      end
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_rready = 0; s_bready = 0;
      chk("t4 read responses", nr, 2);
      chk("t4 write responses", nb, 1);
      chk("t4 first read sees old data", rd[0], 32'h0);
      chk("t4 second read sees write", rd[1], 32'h0BAD_F00D);
      seq = 3'b111;
      for (int i = 0; i < we_log.size() && i < 3; i++) seq[i] = we_log[i];
      chk("t4 access count", we_log.size(), 3);
      chk("t4 access order r,w,r", seq, 3'b010);
    end

    // R backpressure with a second AR waiting.
    begin
      bit got;
      got = 0;
      s_araddr = 32'h0000_0040; s_arvalid = 1; s_rready = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        got = s_rvalid;
      end
      chk("t6 rvalid seen", got, 1'b1);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("t6 stall%0d rvalid", k), s_rvalid, 1'b1);
        chk($sformatf("t6 stall%0d rdata", k), s_rdata, 32'h0BAD_F00D);
        chk($sformatf("t6 stall%0d arready", k), s_arready, 1'b0);
        @(negedge clk);
      end
      s_rready = 1;
      @(negedge clk);
      chk("t6 rvalid after handshake", s_rvalid, 1'b0);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        if (s_arvalid && s_arready) begin @(negedge clk); s_arvalid = 0; end
        else @(negedge clk);
        got = s_rvalid;
      end
      chk("t6 second read data", s_rdata, 32'h0BAD_F00D);
      @(negedge clk);
      s_rready = 0; s_arvalid = 0;
    end

    // Asynchronous reset while the read is at the SRAM.
    begin
      bit seen;
      seen = 0;
      s_araddr = 32'h0000_0040; s_arvalid = 1; s_rready = 1;
      chk("t6b arready", s_arready, 1'b1);
      @(negedge clk);
      s_arvalid = 0;
      chk("t6b in RD", sram_cs, 1'b1);
      #1 resetn = 1'b0;
      #1 chk("t6b outputs cleared", any_output(), 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (s_rvalid) seen = 1;
      end
      chk("t6b no stale R", seen, 1'b0);
      chk("t6b arready back", s_arready, 1'b1);
      s_rready = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_sram_responder.md
Name: axi_lite_sram_responder

Overview:
AXI4-Lite responder (slave end) that serves the PicoRV32 mem_axi master's accesses to the firmware/data SRAM window. It accepts independent AW/W/AR channels and converts each transaction into single-cycle accesses on a single-port synchronous SRAM with 1-cycle read latency and a byte-lane write mask. It returns B/R responses with full backpressure support. It sits behind the system_top address decoder, in parallel with the AES register responder.

Parameters:
MEM_AW, 9, SRAM word-address width; window holds 2^MEM_AW 32-bit words.
ADDR_W, 32, AXI address width.

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awaddr  in  ADDR_W  write byte address
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_araddr  in  ADDR_W  read byte address
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  32  read data
s_rresp  out  2  read response
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_addr  out  MEM_AW  SRAM word address
sram_wdata  out  32  SRAM write data
sram_wmask  out  4  SRAM byte write mask
sram_rdata  in  32  SRAM read data, valid the cycle after a read cs

Behaviour:
- Reset (resetn=0, asynchronous): every output is 0, both holding buffers are empty, state is IDLE, and the priority flag is set to read-first. Reset mid-transaction drops the transaction silently and issues no response.
- AW and W buffers are independent, one entry each. s_awready = !aw_full; s_wready = !w_full. Either channel may arrive first or both in the same cycle. A buffer clears only when its write is issued to the SRAM.
- Word address = addr[MEM_AW+1:2]; addr[1:0] are ignored.
- Out of range: any address with addr[ADDR_W-1:MEM_AW+2] != 0. The transaction completes with resp=10 (SLVERR), sram_cs stays 0, and rdata=0.
- State machine: IDLE, WR, BRESP, RD, RCAP, RRESP. All outputs are registered.
- s_arready=1 only in IDLE, and only when a write is not being selected in that cycle.
- Arbitration in IDLE, when a write is ready (aw_full&&w_full) and s_arvalid=1 in the same cycle: the side opposite to the last-served side wins. The flag toggles on each issue.
- Write timing: IDLE->WR; in WR, sram_cs=1, sram_we=1, sram_wmask=wstrb, for exactly 1 cycle, then BRESP. In BRESP, s_bvalid=1 until s_bready, then IDLE.
- wstrb=0000: SRAM is still accessed with an all-zero mask and the response is OKAY.
- Read timing: the AR handshake happens in cycle N. At N+1 (RD), sram_cs=1 and sram_we=0. At N+2 (RCAP), sram_rdata is captured. At N+3 (RRESP), s_rvalid=1 and s_rdata/s_rresp are stable until s_rready; the next cycle returns to IDLE.
- Minimum write latency from both-buffers-full: s_bvalid 2 cycles later. Minimum read latency: 3 cycles after the AR handshake.
- Only one transaction is in flight at a time. The AW/W buffers may fill while a read is in progress.
- bvalid/rvalid never drop without the matching ready.
- sram_addr, sram_wdata and sram_wmask hold their values when cs=0.

Test Plan:
1. Write 0x0000_0010 data 0xDEADBEEF strb 1111, then read 0x10 -> sram_wmask=1111 at addr 4; BRESP=00; rdata=0xDEADBEEF 3 cycles after the AR handshake.
2. W presented 3 cycles before AW -> s_wready drops after the first handshake; the write issues 1 cycle after AW is accepted; bvalid 2 cycles after that.
3. Write strb 0010 data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
4. Write and read both pending in IDLE, twice in a row -> the first serves the read (post-reset flag), the second serves the write; no deadlock.
5. Read 0x0000_0800 with MEM_AW=9 -> rresp=10, rdata=0, sram_cs never asserted; write to the same address -> bresp=10, no sram_we.
6. Hold s_rready=0 for 5 cycles -> rvalid/rdata stable and new AR not accepted. Assert resetn=0 during RD -> all outputs 0 immediately and no R response after release.
